// File: rtl/if_axi_fetch_ctrl_pkg.sv
// Shared constants and state encoding for the IF-stage AXI-Lite fetch sequencer.
// Imported by the fetch controller top.
package if_axi_fetch_ctrl_pkg;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic        CHIP_ENABLE   = 1'b1;
  localparam logic [31:0] ZEROWORD      = 32'h0000_0000;
  localparam int          INST_ADDR_BUS = 32;

  localparam int                    AXI_RESP_W    = 2;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/if_axi_fetch_ctrl.sv
// IF-stage fetch sequencer: one AXI-Lite AR/R transaction per pc, stalls the
// pipeline while waiting and presents the fetched word to the IF/ID register.
module if_axi_fetch_ctrl
  import if_axi_fetch_ctrl_pkg::*;
#(
  parameter int          ADDR_W   = INST_ADDR_BUS,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] NOP_INST = ZEROWORD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     pc,
  input  logic                  ce,
  input  logic [5:0]            stall,
  input  logic                  flush,
  output logic                  stallreq_if,
  output logic [DATA_W-1:0]     inst,
  output logic                  inst_valid,
  output logic                  fetch_err,
  output logic [ADDR_W-1:0]     araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [AXI_RESP_W-1:0] rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_INST);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic              discard_q, discard_d;
  logic              abort;

  // Only the PC/IF hold bit matters to this stage.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  // A redirect or a dropped chip enable both mean the in-flight word is stale.
  assign abort = flush | (ce != CHIP_ENABLE);

  // NOTE: every _d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    fetch_err_d  = 1'b0;
    discard_d    = discard_q;

    unique case (state_q)
      S_IDLE: begin
        inst_valid_d = 1'b0;
        if (!flush && ce == CHIP_ENABLE) begin
          if (is_word_aligned(pc[1:0])) begin
            araddr_d  = pc;
            arvalid_d = 1'b1;
            state_d   = S_ADDR;
          end else begin
            inst_d      = NOP_WORD;
            fetch_err_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end

      S_ADDR: begin
        if (abort) discard_d = 1'b1;
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (abort) discard_d = 1'b1;
        if (rvalid) begin
          rready_d = 1'b0;
          if (discard_q || abort) begin
            discard_d = 1'b0;
            state_d   = S_IDLE;
          end else if (rresp == AXI_RESP_OKAY) begin
            inst_d       = rdata;
            inst_valid_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            inst_d       = NOP_WORD;
            inst_valid_d = 1'b1;
            fetch_err_d  = 1'b1;
            state_d      = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (flush || !stall[0]) begin
          inst_valid_d = 1'b0;
          inst_d       = NOP_WORD;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q      <= S_IDLE;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_q       <= NOP_WORD;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      fetch_err_q  <= fetch_err_d;
      discard_q    <= discard_d;
    end
  end

  assign stallreq_if = ce & (state_q != S_DONE);
  assign araddr      = araddr_q;
  assign arvalid     = arvalid_q;
  assign rready      = rready_q;
  assign inst        = inst_q;
  assign inst_valid  = inst_valid_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_if_axi_fetch_ctrl.sv
// Directed self-checking bench for if_axi_fetch_ctrl; the bench plays the
// AXI-Lite slave by hand with fixed handshake timing per scenario.
module tb_if_axi_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        ce;
  logic [5:0]  stall;
  logic        flush;
  logic        stallreq_if;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int n_cmp = 0;
  int n_err = 0;

  if_axi_fetch_ctrl dut (
    .clk(clk), .rst(rst), .pc(pc), .ce(ce), .stall(stall), .flush(flush),
    .stallreq_if(stallreq_if), .inst(inst), .inst_valid(inst_valid),
    .fetch_err(fetch_err), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; pc = 32'h0; stall = 6'b0; flush = 1'b0;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hFFFF_FFFF; rresp = 2'b00;
    repeat (3) tick();
    n_cmp++; if (arvalid !== 1'b0) begin n_err++; $display("FAIL reset_arvalid got %b want 0", arvalid); end
    n_cmp++; if (rready !== 1'b0) begin n_err++; $display("FAIL reset_rready got %b want 0", rready); end
    n_cmp++; if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got %h want 00000000", inst); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
    n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL reset_fetch_err got %b want 0", fetch_err); end
    n_cmp++; if (stallreq_if !== 1'b0) begin n_err++; $display("FAIL reset_stallreq got %b want 0", stallreq_if); end
    n_cmp++; if (araddr !== 32'h0) begin n_err++; $display("FAIL reset_araddr got %h want 00000000", araddr); end
    rst = 1'b0; arready = 1'b0; rvalid = 1'b0;
  endtask

  task automatic test_zero_wait();
    ce = 1'b1; pc = 32'h0; arready = 1'b1; rvalid = 1'b1;
    rdata = 32'h3C01_1234; rresp = 2'b00;
    #1;
    n_cmp++; if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL zw_c0_stallreq got %b want 1", stallreq_if); end
    tick();
    n_cmp++; if (arvalid !== 1'b1) begin n_err++; $display("FAIL zw_c1_arvalid got %b want 1", arvalid); end
    n_cmp++; if (araddr !== 32'h0) begin n_err++; $display("FAIL zw_c1_araddr got %h want 00000000", araddr); end
    n_cmp++; if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL zw_c1_stallreq got %b want 1", stallreq_if); end
    tick();
    n_cmp++; if (rready !== 1'b1) begin n_err++; $display("FAIL zw_c2_rready got %b want 1", rready); end
    n_cmp++; if (arvalid !== 1'b0) begin n_err++; $display("FAIL zw_c2_arvalid got %b want 0", arvalid); end
    n_cmp++; if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL zw_c2_stallreq got %b want 1", stallreq_if); end
    tick();
    n_cmp++; if (inst !== 32'h3C01_1234) begin n_err++; $display("FAIL zw_c3_inst got %h want 3c011234", inst); end
    n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL zw_c3_inst_valid got %b want 1", inst_valid); end
    n_cmp++; if (stallreq_if !== 1'b0) begin n_err++; $display("FAIL zw_c3_stallreq got %b want 0", stallreq_if); end
    n_cmp++; if (rready !== 1'b0) begin n_err++; $display("FAIL zw_c3_rready got %b want 0", rready); end
    tick();
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL zw_c4_inst_valid got %b want 0", inst_valid); end
    n_cmp++; if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL zw_c4_stallreq got %b want 1", stallreq_if); end
    ce = 1'b0; arready = 1'b0; rvalid = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    ce = 1'b1; pc = 32'h4; arready = 1'b0; rvalid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (arvalid !== 1'b1 || araddr !== 32'h4) begin n_err++; $display("FAIL ws_ar_hold[%0d] got arvalid=%b araddr=%h want 1/00000004", i, arvalid, araddr); end
      n_cmp++; if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL ws_ar_stallreq[%0d] got %b want 1", i, stallreq_if); end
      if (i == 3) arready = 1'b1;
      tick();
    end
    arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rready !== 1'b1 || arvalid !== 1'b0) begin n_err++; $display("FAIL ws_r_wait[%0d] got rready=%b arvalid=%b want 1/0", i, rready, arvalid); end
      n_cmp++; if (stallreq_if !== 1'b1 || inst_valid !== 1'b0) begin n_err++; $display("FAIL ws_r_stall[%0d] got stallreq=%b inst_valid=%b want 1/0", i, stallreq_if, inst_valid); end
      if (i == 2) begin rvalid = 1'b1; rdata = 32'h8C22_0008; rresp = 2'b00; end
      tick();
    end
    rvalid = 1'b0; stall = 6'b000001;
    n_cmp++; if (inst !== 32'h8C22_0008 || inst_valid !== 1'b1) begin n_err++; $display("FAIL ws_done got inst=%h valid=%b want 8c220008/1", inst, inst_valid); end
    n_cmp++; if (stallreq_if !== 1'b0) begin n_err++; $display("FAIL ws_done_stallreq got %b want 0", stallreq_if); end
    repeat (2) begin
      tick();
      n_cmp++; if (inst !== 32'h8C22_0008 || inst_valid !== 1'b1) begin n_err++; $display("FAIL ws_stall_hold got inst=%h valid=%b want 8c220008/1", inst, inst_valid); end
    end
    stall = 6'b0; ce = 1'b0;
    tick();
    n_cmp++; if (inst_valid !== 1'b0 || stallreq_if !== 1'b0) begin n_err++; $display("FAIL ws_release got valid=%b stallreq=%b want 0/0", inst_valid, stallreq_if); end
  endtask

  task automatic test_error_resp();
    ce = 1'b1; pc = 32'h8; arready = 1'b1; rvalid = 1'b1;
    rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    repeat (3) tick();
    stall = 6'b000001;
    n_cmp++; if (inst !== 32'h0 || inst_valid !== 1'b1) begin n_err++; $display("FAIL err_inst got inst=%h valid=%b want 00000000/1", inst, inst_valid); end
    n_cmp++; if (fetch_err !== 1'b1) begin n_err++; $display("FAIL err_pulse_set got %b want 1", fetch_err); end
    tick();
    n_cmp++; if (fetch_err !== 1'b0 || inst_valid !== 1'b1) begin n_err++; $display("FAIL err_pulse_clear got err=%b valid=%b want 0/1", fetch_err, inst_valid); end
    stall = 6'b0; ce = 1'b0; arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
    tick();
  endtask

  task automatic test_misaligned();
    ce = 1'b1; pc = 32'h6; arready = 1'b1; rvalid = 1'b0;
    #1;
    n_cmp++; if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL mis_c0_stallreq got %b want 1", stallreq_if); end
    tick();
    n_cmp++; if (arvalid !== 1'b0) begin n_err++; $display("FAIL mis_c1_arvalid got %b want 0", arvalid); end
    n_cmp++; if (fetch_err !== 1'b1) begin n_err++; $display("FAIL mis_c1_fetch_err got %b want 1", fetch_err); end
    n_cmp++; if (stallreq_if !== 1'b0 || inst !== 32'h0) begin n_err++; $display("FAIL mis_c1_done got stallreq=%b inst=%h want 0/00000000", stallreq_if, inst); end
    ce = 1'b0;
    tick();
    n_cmp++; if (fetch_err !== 1'b0 || arvalid !== 1'b0) begin n_err++; $display("FAIL mis_c2 got err=%b arvalid=%b want 0/0", fetch_err, arvalid); end
    arready = 1'b0;
  endtask

  task automatic test_flush_data();
    ce = 1'b1; pc = 32'h40; arready = 1'b1; rvalid = 1'b0;
    repeat (2) tick();
    n_cmp++; if (rready !== 1'b1) begin n_err++; $display("FAIL fl_in_data got rready=%b want 1", rready); end
    flush = 1'b1;
    tick();
    flush = 1'b0; pc = 32'h100;
    n_cmp++; if (rready !== 1'b1 || inst_valid !== 1'b0) begin n_err++; $display("FAIL fl_still_data got rready=%b valid=%b want 1/0", rready, inst_valid); end
    rvalid = 1'b1; rdata = 32'h1111_1111;
    tick();
    rvalid = 1'b0; rdata = 32'h2442_0001;
    n_cmp++; if (inst_valid !== 1'b0 || fetch_err !== 1'b0 || rready !== 1'b0) begin n_err++; $display("FAIL fl_dropped got valid=%b err=%b rready=%b want 0/0/0", inst_valid, fetch_err, rready); end
    n_cmp++; if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL fl_idle_stallreq got %b want 1", stallreq_if); end
    tick();
    n_cmp++; if (arvalid !== 1'b1 || araddr !== 32'h100) begin n_err++; $display("FAIL fl_refetch_ar got arvalid=%b araddr=%h want 1/00000100", arvalid, araddr); end
    tick();
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    n_cmp++; if (inst !== 32'h2442_0001 || inst_valid !== 1'b1) begin n_err++; $display("FAIL fl_refetch_data got inst=%h valid=%b want 24420001/1", inst, inst_valid); end
    stall = 6'b000001; flush = 1'b1; ce = 1'b0;
    tick();
    flush = 1'b0; stall = 6'b0;
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL fl_done_priority got valid=%b want 0", inst_valid); end
    arready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_error_resp();
    test_misaligned();
    test_flush_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
